// File: rtl/vesp_top.sv
// vesp SoC: single-cycle RV32I core with a combinational-fetch instruction memory,
// a byte-masked data memory and a memory-mapped GPIO output register.

module cpu (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic [31:0] rdata,
    output logic [31:0] PC,
    output logic [31:0] addr,
    output logic [31:0] wdata,
    output logic        we,
    output logic [3:0]  mask
);
    localparam logic [6:0] OP_LUI = 7'h37, OP_AUIPC = 7'h17, OP_JAL = 7'h6f, OP_JALR = 7'h67;
    localparam logic [6:0] OP_BR = 7'h63, OP_LD = 7'h03, OP_ST = 7'h23, OP_IMM = 7'h13, OP_REG = 7'h33;

    logic [31:0] regs [32];
    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [31:0] a, b, imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] alu_b, alu, lane, ld, result, pc4, pc_next;
    logic        take, wr_rd;

    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign f3     = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign a      = (rs1 == 5'd0) ? '0 : regs[rs1];
    assign b      = (rs2 == 5'd0) ? '0 : regs[rs2];
    assign imm_i  = {{20{instr[31]}}, instr[31:20]};
    assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u  = {instr[31:12], 12'b0};
    assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    assign pc4    = PC + 32'd4;

    // Data port: sub-word stores are lane-shifted here so the memories only see a byte mask.
    assign addr  = a + ((opcode == OP_ST) ? imm_s : imm_i);
    assign we    = (opcode == OP_ST);
    assign wdata = b << {addr[1:0], 3'b000};
    assign lane  = rdata >> {addr[1:0], 3'b000};

    always_comb begin
        case (f3[1:0])
            2'd0:    mask = 4'b0001 << addr[1:0];
            2'd1:    mask = 4'b0011 << addr[1:0];
            default: mask = 4'b1111;
        endcase
    end

    always_comb begin
        alu_b = (opcode == OP_REG) ? b : imm_i;
        case (f3)
            3'd0:    alu = (opcode == OP_REG && instr[30]) ? a - alu_b : a + alu_b;
            3'd1:    alu = a << alu_b[4:0];
            3'd2:    alu = {31'b0, $signed(a) < $signed(alu_b)};
            3'd3:    alu = {31'b0, a < alu_b};
            3'd4:    alu = a ^ alu_b;
            3'd5:    alu = instr[30] ? 32'($signed(a) >>> alu_b[4:0]) : a >> alu_b[4:0];
            3'd6:    alu = a | alu_b;
            default: alu = a & alu_b;
        endcase
    end

    always_comb begin
        case (f3)
            3'd0:    take = (a == b);
            3'd1:    take = (a != b);
            3'd4:    take = ($signed(a) < $signed(b));
            3'd5:    take = ($signed(a) >= $signed(b));
            3'd6:    take = (a < b);
            3'd7:    take = (a >= b);
            default: take = 1'b0;
        endcase
    end

    always_comb begin
        case (f3)
            3'd0:    ld = {{24{lane[7]}}, lane[7:0]};
            3'd1:    ld = {{16{lane[15]}}, lane[15:0]};
            3'd4:    ld = {24'b0, lane[7:0]};
            3'd5:    ld = {16'b0, lane[15:0]};
            default: ld = rdata;
        endcase
    end

    always_comb begin
        result  = alu;
        wr_rd   = 1'b0;
        pc_next = pc4;
        case (opcode)
            OP_LUI:   begin result = imm_u;       wr_rd = 1'b1; end
            OP_AUIPC: begin result = PC + imm_u;  wr_rd = 1'b1; end
            OP_JAL:   begin result = pc4; wr_rd = 1'b1; pc_next = PC + imm_j; end
            OP_JALR:  begin result = pc4; wr_rd = 1'b1; pc_next = (a + imm_i) & ~32'd1; end
            OP_BR:    if (take) pc_next = PC + imm_b;
            OP_LD:    begin result = ld;  wr_rd = 1'b1; end
            OP_IMM, OP_REG: wr_rd = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            PC <= '0;
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else begin
            PC <= pc_next;
            if (wr_rd && rd != 5'd0) regs[rd] <= result;
        end
    end
endmodule

module instr_mem #(
    parameter int WORD_CNT = 1024
) (
    input  logic                        clk,
    input  logic [31:0]                 iaddr,
    input  logic [31:0]                 daddr,
    output logic [31:0]                 idata,
    output logic [31:0]                 ddata,
    input  logic                        load_en,
    input  logic [$clog2(WORD_CNT)-1:0] load_idx,
    input  logic [31:0]                 load_data
);
    localparam int AW = $clog2(WORD_CNT);

    logic [31:0] ram [WORD_CNT];
    logic        unused_lsb;

    assign unused_lsb = ^{iaddr[1:0], daddr[1:0]};
    assign idata = (iaddr[31:AW+2] == '0) ? ram[iaddr[AW+1:2]] : '0;
    assign ddata = (daddr[31:AW+2] == '0) ? ram[daddr[AW+1:2]] : '0;

    // Loader port for a future boot path; tied off at the top, contents arrive by preload.
    always_ff @(posedge clk) begin
        if (load_en) ram[load_idx] <= load_data;
    end
endmodule

module data_mem #(
    parameter int WORD_CNT = 1024
) (
    input  logic                        clk,
    input  logic [$clog2(WORD_CNT)-1:0] idx,
    input  logic [31:0]                 wdata,
    input  logic                        we,
    input  logic [3:0]                  mask,
    output logic [31:0]                 rdata
);
    logic [31:0] ram [WORD_CNT];

    assign rdata = ram[idx];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++)
                if (mask[i]) ram[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
    end
endmodule

module vesp_top (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] gpioOut
);
    localparam int INSTR_MEM_WORD_CNT = 1024;
    localparam int DATA_MEM_WORD_CNT  = 1024;
    localparam int IAW = $clog2(INSTR_MEM_WORD_CNT);
    localparam int DAW = $clog2(DATA_MEM_WORD_CNT);

    logic [31:0] PC, iRead, addr, wdata, rdata, imem_rdata, dmem_rdata, doff, gpio;
    logic [3:0]  mask;
    logic        we, sel_imem, sel_dmem, sel_gpio;

    cpu cpuInst (
        .clk(clk), .reset(reset), .instr(iRead), .rdata(rdata), .PC(PC),
        .addr(addr), .wdata(wdata), .we(we), .mask(mask)
    );

    instr_mem #(.WORD_CNT(INSTR_MEM_WORD_CNT)) instrMemInst (
        .clk(clk), .iaddr(PC), .daddr(addr), .idata(iRead), .ddata(imem_rdata),
        .load_en(1'b0), .load_idx({IAW{1'b0}}), .load_data(32'h0)
    );

    assign doff     = addr - 32'h0001_0000;
    assign sel_imem = (addr[31:16] == 16'h0000);
    assign sel_dmem = !sel_imem && (doff < 32'(4 * DATA_MEM_WORD_CNT));
    assign sel_gpio = (addr[31:2] == 30'h3C00_0000);

    data_mem #(.WORD_CNT(DATA_MEM_WORD_CNT)) dataMemInst (
        .clk(clk), .idx(doff[DAW+1:2]), .wdata(wdata), .we(we && sel_dmem),
        .mask(mask), .rdata(dmem_rdata)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            gpio <= '0;
        end else if (we && sel_gpio) begin
            for (int i = 0; i < 4; i++)
                if (mask[i]) gpio[8*i +: 8] <= wdata[8*i +: 8];
        end
    end

    assign gpioOut = gpio;

    // Unmapped addresses read as zero; their writes are dropped by the gated enables above.
    always_comb begin
        rdata = '0;
        if (sel_imem)      rdata = imem_rdata;
        else if (sel_dmem) rdata = dmem_rdata;
        else if (sel_gpio) rdata = gpio;
    end
endmodule

// File: tb/tb_vesp_top.sv
// Scoreboard bench for vesp_top: small hand-assembled programs, expected values
// queued when a program is set up and popped as each result is observed.

module tb_vesp_top;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] gpioOut;

    int n_chk = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];
    logic [31:0] prog[$];

    vesp_top dut (.clk(clk), .reset(reset), .gpioOut(gpioOut));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_next(input string tag, input logic [31:0] obs);
        if (exp_q.size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL %s: scoreboard empty, got %h", tag, obs);
        end else begin
            chk(tag, obs, exp_q.pop_front());
        end
    endtask

    function automatic logic [31:0] enc_i(logic [31:0] imm, logic [4:0] rs1, logic [2:0] f3,
                                          logic [4:0] rd, logic [6:0] op);
        return {imm[11:0], rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] addi(logic [4:0] rd, logic [4:0] rs1, logic [31:0] imm);
        return enc_i(imm, rs1, 3'd0, rd, 7'h13);
    endfunction
    function automatic logic [31:0] lw(logic [4:0] rd, logic [4:0] rs1, logic [31:0] imm);
        return enc_i(imm, rs1, 3'd2, rd, 7'h03);
    endfunction
    function automatic logic [31:0] lui(logic [4:0] rd, logic [19:0] imm);
        return {imm, rd, 7'h37};
    endfunction
    function automatic logic [31:0] st(logic [2:0] f3, logic [4:0] rs2, logic [4:0] rs1, logic [31:0] imm);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] br(logic [2:0] f3, logic [4:0] rs1, logic [4:0] rs2, logic [31:0] off);
        return {off[12], off[10:5], rs2, rs1, f3, off[4:1], off[11], 7'h63};
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Unused instruction words hold "jal x0,0" so a program parks instead of running on.
    task automatic load_prog();
        for (int i = 0; i < 1024; i++)
            dut.instrMemInst.ram[i] = (i < prog.size()) ? prog[i] : 32'h0000_006f;
    endtask

    task automatic restart();
        reset = 1'b0;
        step(3);
        reset = 1'b1;
    endtask

    task automatic run_marker(input int budget, output logic hit_pass, output logic hit_fail);
        hit_pass = 1'b0;
        hit_fail = 1'b0;
        for (int c = 0; c < budget && !hit_pass && !hit_fail; c++) begin
            step(1);
            if (dut.iRead === 32'h1) hit_pass = 1'b1;
            else if (dut.iRead === 32'h0) hit_fail = 1'b1;
        end
    endtask

    logic hp, hf;

    initial begin
        for (int i = 0; i < 1024; i++) dut.dataMemInst.ram[i] = '0;

        // Reset and straight-line PC advance
        prog = '{addi(1, 0, 1), addi(2, 0, 2), addi(3, 0, 3), addi(4, 0, 4)};
        load_prog();
        exp_q.push_back(32'h0);
        exp_q.push_back(prog[0]);
        exp_q.push_back(32'h0);
        for (int k = 1; k <= 3; k++) exp_q.push_back(32'(4 * k));
        step(3);
        chk_next("rst_pc", dut.cpuInst.PC);
        chk_next("rst_iread", dut.iRead);
        chk_next("rst_gpio", gpioOut);
        reset = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step(1);
            chk_next("pc_adv", dut.cpuInst.PC);
        end

        // Pass marker: branch taken skips the fail word
        prog = '{addi(3, 0, 8), addi(1, 0, 5), addi(2, 1, 3), br(3'd0, 2, 3, 8), 32'h0, 32'h1};
        load_prog();
        exp_q.push_back(32'h1);
        exp_q.push_back(32'h0);
        restart();
        run_marker(10, hp, hf);
        chk_next("pass_hit", {31'b0, hp});
        chk_next("pass_no_fail", {31'b0, hf});

        // Branch not taken falls into the fail word
        prog = '{addi(3, 0, 9), addi(1, 0, 5), addi(2, 1, 3), br(3'd0, 2, 3, 8), 32'h0, 32'h1};
        load_prog();
        exp_q.push_back(32'h1);
        restart();
        run_marker(10, hp, hf);
        chk_next("fallthru_fail", {31'b0, hf});

        // Data memory byte lanes
        prog = '{lui(1, 20'h11223), addi(1, 1, 32'h344), lui(2, 20'h00010), st(3'd2, 1, 2, 0),
                 addi(3, 0, 32'hAA), st(3'd0, 3, 2, 1), lw(4, 2, 0)};
        load_prog();
        exp_q.push_back(32'h1122AA44);
        exp_q.push_back(32'h1122AA44);
        restart();
        step(8);
        chk_next("dmem_lw", dut.cpuInst.regs[4]);
        chk_next("dmem_ram0", dut.dataMemInst.ram[0]);

        // GPIO store, load-back, then reset clears it and restarts at 0
        prog = '{lui(1, 20'hDEADC), addi(1, 1, -32'sd273), lui(2, 20'hF0000), st(3'd2, 1, 2, 0),
                 lw(5, 2, 0)};
        load_prog();
        exp_q.push_back(32'h0);
        exp_q.push_back(32'hDEADBEEF);
        exp_q.push_back(32'hDEADBEEF);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        restart();
        step(3);
        chk_next("gpio_before", gpioOut);
        step(1);
        chk_next("gpio_after", gpioOut);
        step(2);
        chk_next("gpio_lw", dut.cpuInst.regs[5]);
        restart();
        chk_next("rerst_gpio", gpioOut);
        chk_next("rerst_pc", dut.cpuInst.PC);
        step(1);
        chk_next("rerst_pc_adv", dut.cpuInst.PC);

        // Unmapped address: store dropped, load reads zero
        dut.dataMemInst.ram[0] = 32'hCAFEF00D;
        prog = '{addi(6, 0, 32'h77), lui(1, 20'h80000), addi(2, 0, 32'h55), st(3'd2, 2, 1, 0),
                 lw(6, 1, 0)};
        load_prog();
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'hCAFEF00D);
        exp_q.push_back(prog[0]);
        restart();
        step(6);
        chk_next("unmap_lw", dut.cpuInst.regs[6]);
        chk_next("unmap_gpio", gpioOut);
        chk_next("unmap_dmem", dut.dataMemInst.ram[0]);
        chk_next("unmap_imem", dut.instrMemInst.ram[0]);

        // Counting loop that ends on the pass marker
        prog = '{addi(1, 0, 0), addi(2, 0, 10), addi(1, 1, 1), br(3'd1, 1, 2, -32'sd4), 32'h1};
        load_prog();
        exp_q.push_back(32'h1);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'd10);
        restart();
        run_marker(100, hp, hf);
        chk_next("loop_pass", {31'b0, hp});
        chk_next("loop_no_fail", {31'b0, hf});
        chk_next("loop_count", dut.cpuInst.regs[1]);

        chk("sb_drain", 32'(exp_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
